// File: rtl/cim_bank.sv
// Compute-in-memory weight bank: ROWS rows of paired A/B half-words, written via
// a row-select vector and continuously exposed on flat output buses.
module cim_bank #(
  parameter int ROWS   = 8,
  parameter int HALF_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2*HALF_W-1:0]      D,
  input  logic [ROWS-1:0]          WA,
  output logic [ROWS*HALF_W-1:0]   wb_a,
  output logic [ROWS*HALF_W-1:0]   wb_b
);

  logic [HALF_W-1:0] r_a [ROWS];
  logic [HALF_W-1:0] r_b [ROWS];

  logic [HALF_W-1:0] w_d_a;
  logic [HALF_W-1:0] w_d_b;

  assign w_d_a = D[2*HALF_W-1:HALF_W];
  assign w_d_b = D[HALF_W-1:0];

  // Reset wins over writes; WA may select any number of rows at once.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ROWS; i++) begin
      if (rst) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end else if (WA[i]) begin
        r_a[i] <= w_d_a;
        r_b[i] <= w_d_b;
      end
    end
  end

  always_comb begin
    wb_a = '0;
    wb_b = '0;
    for (int i = 0; i < ROWS; i++) begin
      wb_a[i*HALF_W +: HALF_W] = r_a[i];
      wb_b[i*HALF_W +: HALF_W] = r_b[i];
    end
  end

endmodule

// File: tb/tb_cim_bank.sv
// Directed self-checking bench for cim_bank: reset, fill, overwrite, no-op,
// multi-row and broadcast writes, and reset-over-write priority.
module tb_cim_bank;

  logic        clk;
  logic        rst;
  logic [23:0] D;
  logic [7:0]  WA;
  logic [95:0] wb_a;
  logic [95:0] wb_b;

  int n_total;
  int n_pass;

  logic [95:0] exp_a;
  logic [95:0] exp_b;

  cim_bank #(.ROWS(8), .HALF_W(12)) dut (
    .clk  (clk),
    .rst  (rst),
    .D    (D),
    .WA   (WA),
    .wb_a (wb_a),
    .wb_b (wb_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    WA  = 8'h00;
    D   = 24'h000000;

    tick();
    tick();
    check("reset_a", wb_a, 96'h0);
    check("reset_b", wb_b, 96'h0);

    rst = 1'b0;
    exp_a = '0;
    exp_b = '0;
    for (int i = 0; i < 8; i++) begin
      WA = 8'(1 << i);
      D  = {12'(12'h100 + i), 12'(12'hA00 + i)};
      exp_a[12*i +: 12] = 12'(12'h100 + i);
      exp_b[12*i +: 12] = 12'(12'hA00 + i);
      tick();
      check($sformatf("fill_a_row%0d", i), wb_a, exp_a);
      check($sformatf("fill_b_row%0d", i), wb_b, exp_b);
    end
    check("fill_a_final", wb_a, 96'h107106105104103102101100);
    check("fill_b_final", wb_b, 96'hA07A06A05A04A03A02A01A00);

    WA = 8'h10;
    D  = 24'hDEADBE;
    tick();
    check("overwrite_a", wb_a, 96'h107106105DEA103102101100);
    check("overwrite_b", wb_b, 96'hA07A06A05DBEA03A02A01A00);

    WA = 8'h00;
    D  = 24'hFFFFFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("noop_a_%0d", k), wb_a, 96'h107106105DEA103102101100);
      check($sformatf("noop_b_%0d", k), wb_b, 96'hA07A06A05DBEA03A02A01A00);
    end

    WA = 8'h81;
    D  = 24'h5A5C3C;
    tick();
    WA = 8'h00;
    check("multi_a", wb_a, 96'h5A5106105DEA1031021015A5);
    check("multi_b", wb_b, 96'hC3CA06A05DBEA03A02A01C3C);
    tick();
    check("multi_hold_a", wb_a, 96'h5A5106105DEA1031021015A5);
    check("multi_hold_b", wb_b, 96'hC3CA06A05DBEA03A02A01C3C);

    WA = 8'hFF;
    D  = 24'h123456;
    tick();
    check("broadcast_a", wb_a, 96'h123123123123123123123123);
    check("broadcast_b", wb_b, 96'h456456456456456456456456);

    rst = 1'b1;
    WA  = 8'hFF;
    D   = 24'hFFFFFF;
    tick();
    check("rst_prio_a", wb_a, 96'h0);
    check("rst_prio_b", wb_b, 96'h0);

    rst = 1'b0;
    WA  = 8'h04;
    D   = 24'hABC321;
    tick();
    WA  = 8'h00;
    check("post_rst_a", wb_a, 96'h000000000000000ABC000000);
    check("post_rst_b", wb_b, 96'h000000000000000321000000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
